// File: rtl/memory_bus_bridge.sv
// Single-outstanding bridge from the controller's memory port to a variable-latency bus,
// with a wait-state timeout so a dead bus cannot hang the core. All outputs are registered.
//
// Handshake: a request is taken on a rising edge where memory_enable && memory_ready.
// memory_valid is a one-cycle completion pulse, qualified by memory_error. memory_ready is
// never high in the same cycle as memory_valid. On the bus side, bus_request stays high
// until the edge where bus_acknowledge is sampled high, or until the timeout fires.
module memory_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_byte_enable,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] memory_read_data,
  output logic        memory_error,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  input  logic        bus_acknowledge,
  input  logic [31:0] bus_read_data,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam bit                     TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  logic                   ready_next, valid_next, error_next;
  logic                   request_next, write_next;
  logic [31:0]            read_data_next, address_next, write_data_next;
  logic [3:0]             byte_enable_next;

  assign debug_state = state;

  always_comb begin
    state_next       = state;
    count_next       = count;
    ready_next       = memory_ready;
    valid_next       = memory_valid;
    error_next       = memory_error;
    read_data_next   = memory_read_data;
    request_next     = bus_request;
    write_next       = bus_write;
    address_next     = bus_address;
    write_data_next  = bus_write_data;
    byte_enable_next = bus_byte_enable;

    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (memory_enable && memory_ready) begin
          write_next       = memory_command;
          address_next     = memory_address;
          write_data_next  = memory_write_data;
          byte_enable_next = memory_command ? memory_byte_enable : 4'b1111;
          request_next     = 1'b1;
          ready_next       = 1'b0;
          count_next       = '0;
          state_next       = BUS;
        end
      end
      BUS: begin
        if (bus_acknowledge) begin
          request_next = 1'b0;
          valid_next   = 1'b1;
          error_next   = 1'b0;
          if (!bus_write) read_data_next = bus_read_data;
          state_next   = RESP;
        end else begin
          // Saturate rather than wrap so the timeout compare cannot be skipped.
          if (count != COUNT_MAX) count_next = count + 1'b1;
          if (TIMEOUT_ON && (count == TIMEOUT_LAST)) begin
            request_next = 1'b0;
            valid_next   = 1'b1;
            error_next   = 1'b1;
            if (!bus_write) read_data_next = '0;
            state_next   = RESP;
          end
        end
      end
      RESP: begin
        valid_next = 1'b0;
        error_next = 1'b0;
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      count            <= '0;
      memory_ready     <= 1'b0;
      memory_valid     <= 1'b0;
      memory_error     <= 1'b0;
      memory_read_data <= '0;
      bus_request      <= 1'b0;
      bus_write        <= 1'b0;
      bus_address      <= '0;
      bus_write_data   <= '0;
      bus_byte_enable  <= '0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      memory_ready     <= ready_next;
      memory_valid     <= valid_next;
      memory_error     <= error_next;
      memory_read_data <= read_data_next;
      bus_request      <= request_next;
      bus_write        <= write_next;
      bus_address      <= address_next;
      bus_write_data   <= write_data_next;
      bus_byte_enable  <= byte_enable_next;
    end
  end

endmodule
